mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Multi-cycle load/store unit between the RV32I controller/ALU and the data-memory bus. It takes the decoded memory controls (`mem_r`, `mem_w`, `B_H_W`, `sign`), the ALU-computed address and the store data. It runs one request/acknowledge bus transaction per access and stalls the core until the access completes. It returns byte/half/word load data, extended to 32 bits, for the register write-back mux.

## Interface
- `TIMEOUT`, default 255: maximum number of BUSY cycles without `bus_ack` before the access is aborted with `bus_err`; 8-bit counter.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_r`  in  1  load request; decoded from `data_to_reg==2'b01`.
- `mem_w`  in  1  store request.
- `B_H_W`  in  2  access size: 00 word, 01 byte, 10 half, 11 treated as word.
- `sign`  in  1  1 = sign-extend loads, 0 = zero-extend.
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  store data (rs2).
- `rdata`  out  32  extended load data; valid in DONE.
- `stall`  out  1  core must hold its PC and pipeline state.
- `misalign`  out  1  combinational flag: the access presented in IDLE is misaligned.
- `bus_err`  out  1  the access ended by timeout; valid in DONE.
- `bus_req`  out  1  bus request, registered.
- `bus_we`  out  1  1 = write, registered.
- `bus_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`, registered.
- `bus_be`  out  4  byte enables, registered.
- `bus_wdata`  out  32  lane-replicated store data, registered.
- `bus_ack`  in  1  transaction complete; sampled only in BUSY.
- `bus_rdata`  in  32  read word; valid in the `bus_ack` cycle.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- Access present: `acc = mem_r | mem_w`. If both are high, the access is a store (`mem_w` wins).
- Misaligned access:
  - half with `addr[0]=1`;
  - word with `addr[1:0]!=0`.
  - Byte accesses are never misaligned.
- IDLE:
  - No `acc`: stay in IDLE.
  - `acc` and misaligned:
    - `misalign=1`, `stall=0`, no bus activity;
    - stay in IDLE; `rdata` is driven to 0.
  - `acc` and aligned:
    - latch the bus outputs and `addr[1:0]`, `B_H_W`, `sign`;
    - `bus_req<=1`, clear the timeout counter;
    - go to BUSY.
- BUSY: hold all bus outputs stable.
  - `bus_ack=1`:
    - capture the load result into `rdata`;
    - `bus_req<=0`, `bus_err<=0`;
    - go to DONE.
  - Else, counter reaches `TIMEOUT`:
    - `bus_req<=0`, `bus_err<=1`, `rdata<=0`;
    - go to DONE.
  - Else: increment the counter.
- DONE:
  - `stall=0`, `rdata`/`bus_err` held, for exactly one cycle;
  - next state IDLE. The core retires the instruction at this edge.
  - `acc` in DONE is not restarted. It still belongs to the completed instruction.
- `stall = (IDLE & acc & ~misaligned) | BUSY`.
- Store byte enables:
  - byte: `4'b0001 << addr[1:0]`;
  - half: `addr[1] ? 4'b1100 : 4'b0011`;
  - word: `4'b1111`.
- Store data lanes:
  - byte: `{4{wdata[7:0]}}`;
  - half: `{2{wdata[15:0]}}`;
  - word: `wdata`.
- Load extraction:
  - byte lane selected by `addr[1:0]`;
  - half lane selected by `addr[1]`;
  - extend with bit 7 / bit 15 when `sign=1`, with zeros otherwise;
  - word: unmodified.
- `bus_we=1` for stores and 0 for loads. For loads, `bus_be` reflects the access size (same encoding as stores).

## Timing
- Reset values: state IDLE, and `bus_req=0`, `bus_we=0`, `bus_addr=0`, `bus_be=0`, `bus_wdata=0`, `rdata=0`, `bus_err=0`, counter 0.
- Combinational outputs follow the state, so `stall`=0 and `misalign`=0 while no access is presented.
- Reset is asynchronous. Asserting `rst` mid-access drops `bus_req` immediately and abandons the transaction without a DONE cycle.
- Cycle numbering for an access presented in cycle 0:
  - cycle 0: IDLE, `stall=1`;
  - cycle 1: `bus_req=1`.
- Latency:
  - ack in cycle k (k≥1) → DONE in cycle k+1;
  - minimum access time is 3 cycles, with the core stalled for 2 of them.
- Timeout: with no ack, `bus_req` is high for `TIMEOUT+1` cycles, then one DONE cycle with `bus_err=1`.
- `bus_ack` in IDLE or DONE is ignored.

## Test plan
- Aligned LW at `0x100`, ack in cycle 1, `bus_rdata=0xDEADBEEF`:
  - `bus_req` high exactly in cycle 1, `bus_be=4'b1111`;
  - DONE in cycle 2 with `rdata=0xDEADBEEF`, `stall` pattern 1,1,0.
- LB at `0x103`, `sign=1`, `bus_rdata=0x80FFFFFF` → `bus_be=4'b1000`, `rdata=0xFFFFFF80`. LBU, same stimulus → `rdata=0x00000080`.
- SH at `0x102`, `wdata=0x1234ABCD`, ack after 3 wait cycles:
  - `bus_be=4'b1100`, `bus_wdata=0xABCDABCD`, `bus_we=1`;
  - bus outputs stable through all wait cycles.
- LW at `0x101` and LH at `0x003` → `misalign=1`, `stall=0`, `bus_req` never rises.
- Load with `bus_ack` never asserted, `TIMEOUT=4`:
  - `bus_req` high for 5 cycles;
  - then DONE with `bus_err=1`, `rdata=0`, and return to IDLE.
- `rst` asserted while in BUSY → `bus_req=0` immediately, state IDLE. A following SW at `0x8` completes normally with `bus_be=4'b1111`.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV32I load/store unit driving a req/ack data-memory bus
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [1:0]  B_H_W,
  input  logic        sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t      state, state_next;
  logic [7:0]  cnt;
  logic [1:0]  lat_off;
  logic [1:0]  lat_size;
  logic        lat_sign;
  logic [31:0] rdata_q;

  logic        acc;
  logic        is_byte;
  logic        is_half;
  logic        misaligned;
  logic        start;
  logic        timeout_hit;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Request decode; size 2'b11 falls through to word handling.
  always_comb begin
    acc        = mem_r | mem_w;
    is_byte    = (B_H_W == 2'b01);
    is_half    = (B_H_W == 2'b10);
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = wdata;
    if (is_byte) begin
      be_next    = 4'b0001 << addr[1:0];
      wdata_next = {4{wdata[7:0]}};
    end else if (is_half) begin
      misaligned = addr[0];
      be_next    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_next = {2{wdata[15:0]}};
    end else begin
      misaligned = |addr[1:0];
    end
  end

  assign timeout_hit = (cnt == TIMEOUT_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DONE always returns to IDLE so an access still presented there is not restarted.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    stall      = 1'b0;
    misalign   = 1'b0;
    case (state)
      S_IDLE: begin
        if (acc) begin
          if (misaligned) begin
            misalign = 1'b1;
          end else begin
            stall      = 1'b1;
            start      = 1'b1;
            state_next = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (bus_ack || timeout_hit) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Lane extraction uses the offset/size/sign captured at issue, not the live inputs.
  always_comb begin
    case (lat_off)
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = lat_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (lat_size)
      2'b01:   ld_data = {{24{lat_sign & ld_byte[7]}}, ld_byte};
      2'b10:   ld_data = {{16{lat_sign & ld_half[15]}}, ld_half};
      default: ld_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
      bus_err   <= 1'b0;
      rdata_q   <= 32'd0;
      cnt       <= 8'd0;
      lat_off   <= 2'd0;
      lat_size  <= 2'd0;
      lat_sign  <= 1'b0;
    end else if (start) begin
      bus_req   <= 1'b1;
      bus_we    <= mem_w;
      bus_addr  <= {addr[31:2], 2'b00};
      bus_be    <= be_next;
      bus_wdata <= wdata_next;
      cnt       <= 8'd0;
      lat_off   <= addr[1:0];
      lat_size  <= B_H_W;
      lat_sign  <= sign;
    end else if (state == S_BUSY) begin
      if (bus_ack) begin
        bus_req <= 1'b0;
        bus_err <= 1'b0;
        rdata_q <= ld_data;
      end else if (timeout_hit) begin
        bus_req <= 1'b0;
        bus_err <= 1'b1;
        rdata_q <= 32'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign rdata = misalign ? 32'd0 : rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        mem_r;
  logic        mem_w;
  logic [1:0]  B_H_W;
  logic        sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    bit          chk_rd;
  } exp_t;

  exp_t sb[$];

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_r     (mem_r),
    .mem_w     (mem_w),
    .B_H_W     (B_H_W),
    .sign      (sign),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .misalign  (misalign),
    .bus_err   (bus_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access: ack_cycle is the cycle number (1 = first BUSY cycle) carrying bus_ack, 0 = never.
  task automatic run_access(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd, input int ack_cycle,
                            input logic [31:0] brd, input logic [3:0] ebe, input logic [31:0] ewd,
                            input logic [31:0] erd, input logic eerr, input int ereq);
    int   req_cycles;
    bit   done;
    exp_t e;
    req_cycles = 0;
    done = 0;
    sb.push_back('{rd: erd, err: eerr, chk_rd: !w});
    @(posedge clk); #1;
    mem_r = !w; mem_w = w; B_H_W = sz; sign = sg; addr = a; wdata = wd;
    @(negedge clk);
    chk({tag, ".c0_stall"}, stall, 1);
    chk({tag, ".c0_req"}, bus_req, 0);
    chk({tag, ".c0_misalign"}, misalign, 0);
    for (int n = 1; n <= 40 && !done; n++) begin
      @(posedge clk); #1;
      bus_ack = (n == ack_cycle);
      bus_rdata = (n == ack_cycle) ? brd : $urandom;
      @(negedge clk);
      if (bus_req) begin
        req_cycles++;
        chk({tag, ".stall"}, stall, 1);
        chk({tag, ".we"}, bus_we, w);
        chk({tag, ".addr"}, bus_addr, {a[31:2], 2'b00});
        chk({tag, ".be"}, bus_be, ebe);
        chk({tag, ".wdata"}, bus_wdata, ewd);
      end else begin
        done = 1;
        chk({tag, ".done_stall"}, stall, 0);
        chk({tag, ".req_cycles"}, req_cycles, ereq);
        chk({tag, ".sb_nonempty"}, sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          if (e.chk_rd) chk({tag, ".rdata"}, rdata, e.rd);
          chk({tag, ".bus_err"}, bus_err, e.err);
        end
      end
    end
    chk({tag, ".completed"}, done, 1);
    @(posedge clk); #1;
    bus_ack = 0; mem_r = 0; mem_w = 0;
    @(negedge clk);
    chk({tag, ".idle_stall"}, stall, 0);
    chk({tag, ".idle_req"}, bus_req, 0);
  endtask

  task automatic run_misaligned(input string tag, input logic [1:0] sz, input logic [31:0] a);
    @(posedge clk); #1;
    mem_r = 1; mem_w = 0; B_H_W = sz; sign = 0; addr = a; wdata = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk({tag, ".misalign"}, misalign, 1);
      chk({tag, ".stall"}, stall, 0);
      chk({tag, ".req"}, bus_req, 0);
      chk({tag, ".rdata"}, rdata, 0);
      @(posedge clk); #1;
    end
    mem_r = 0;
    @(negedge clk);
    chk({tag, ".cleared"}, misalign, 0);
  endtask

  initial begin
    rst = 1; mem_r = 0; mem_w = 0; B_H_W = 0; sign = 0; addr = 0; wdata = 0;
    bus_ack = 0; bus_rdata = 0;
    @(negedge clk);
    chk("rst.req", bus_req, 0);
    chk("rst.we", bus_we, 0);
    chk("rst.addr", bus_addr, 0);
    chk("rst.be", bus_be, 0);
    chk("rst.wdata", bus_wdata, 0);
    chk("rst.rdata", rdata, 0);
    chk("rst.err", bus_err, 0);
    chk("rst.stall", stall, 0);
    chk("rst.misalign", misalign, 0);
    @(posedge clk); #1;
    rst = 0;

    run_access("lw100", 0, 2'b00, 0, 32'h100, 32'h0, 1, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF, 0, 1);
    run_access("lb103", 0, 2'b01, 1, 32'h103, 32'h0, 1, 32'h80FFFFFF, 4'b1000, 32'h0, 32'hFFFFFF80, 0, 1);
    run_access("lbu103", 0, 2'b01, 0, 32'h103, 32'h0, 1, 32'h80FFFFFF, 4'b1000, 32'h0, 32'h00000080, 0, 1);
    run_access("sh102", 1, 2'b10, 0, 32'h102, 32'h1234ABCD, 4, 32'h0, 4'b1100, 32'hABCDABCD, 32'h0, 0, 4);
    run_access("lhu000", 0, 2'b10, 0, 32'h200, 32'h0, 2, 32'h1234F00D, 4'b0011, 32'h0, 32'h0000F00D, 0, 2);
    run_misaligned("lw101", 2'b00, 32'h101);
    run_misaligned("lh003", 2'b10, 32'h003);
    run_access("lw_tmo", 0, 2'b00, 0, 32'h40, 32'h0, 0, 32'h0, 4'b1111, 32'h0, 32'h0, 1, 5);
    run_access("lh202", 0, 2'b10, 1, 32'h202, 32'h0, 1, 32'h80010000, 4'b1100, 32'h0, 32'hFFFF8001, 0, 1);
    run_access("sb001", 1, 2'b01, 0, 32'h001, 32'hCAFE00A5, 1, 32'h0, 4'b0010, 32'hA5A5A5A5, 32'h0, 0, 1);

    @(posedge clk); #1;
    mem_r = 1; mem_w = 0; B_H_W = 2'b00; sign = 0; addr = 32'h300;
    @(posedge clk); #1;
    chk("rstbusy.req_before", bus_req, 1);
    #2;
    rst = 1; mem_r = 0;
    #1;
    chk("rstbusy.req", bus_req, 0);
    chk("rstbusy.stall", stall, 0);
    chk("rstbusy.be", bus_be, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rstbusy.idle_req", bus_req, 0);
    run_access("sw008", 1, 2'b00, 0, 32'h8, 32'h55AA1234, 2, 32'h0, 4'b1111, 32'h55AA1234, 32'h0, 0, 2);

    chk("sb.empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
